// File: rtl/gauss_win_pkg.sv
// -----------------------------------------------------------------------------
// gauss_win_pkg
// Shared types and helpers for the horizontal window generator of the Gaussian
// filter datapath.
//   win_state_t : FILL (priming the window), RUN (one window per pixel),
//                 FLUSH (draining the line end with right padding)
//   half_w()    : half-width H of a K-tap window
//   PAD_ZERO    : pad value used by the zero-padding build
// -----------------------------------------------------------------------------
package gauss_win_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_t;

  localparam int PAD_ZERO = 0;

  function automatic int half_w(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/win_shift_reg.sv
// -----------------------------------------------------------------------------
// win_shift_reg
// K x DATA_W tap register. Tap 0 (the oldest pixel) sits in the MSB slice of
// the packed window and tap K-1 (the newest) sits in the LSB slice.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (taps clear to 0)
//   shift_en     : shift one pixel in on the right, dropping the oldest
//   shift_data   : pixel entering the LSB slice on a shift
//   load_en      : parallel preload of the whole window (wins over shift)
//   load_win     : preload value, same packing as win
//   win          : packed window
// -----------------------------------------------------------------------------
module win_shift_reg #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                shift_en,
  input  logic [DATA_W-1:0]   shift_data,
  input  logic                load_en,
  input  logic [K*DATA_W-1:0] load_win,
  output logic [K*DATA_W-1:0] win
);

  // NOTE: the window is an output that must read 0 straight out of reset, so
  // this small tap register is reset, unlike a RAM-style storage array.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: non-blocking assignments on every register so all taps update
      // from the same pre-edge values.
      win <= '0;
    end else if (load_en) begin
      win <= load_win;
    end else if (shift_en) begin
      win <= {win[(K-1)*DATA_W-1:0], shift_data};
    end
  end

endmodule

// File: rtl/line_window_stream.sv
// -----------------------------------------------------------------------------
// line_window_stream
// Horizontal sliding-window generator: one centred K-tap window per input
// pixel, with per-line left/right border padding.
// Build option: define WIN_BORDER_REPLICATE_EN for edge replication
// (left pad = first pixel, right pad = last pixel); otherwise pads are zero.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_valid/i_data : input pixel, accepted when i_valid & o_ready
//   i_eol          : accepted pixel is the last of its line
//   o_ready        : block can accept a pixel (low while flushing a line end)
//   o_valid        : one-cycle strobe, o_win holds a window
//   o_win          : window, MSB slice = leftmost pixel
//   o_sol / o_eol  : window is centred on the first / last column of a line
// -----------------------------------------------------------------------------
module line_window_stream
  import gauss_win_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3   // odd, >= 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_eol,
  output logic                o_ready,
  output logic                o_valid,
  output logic [K*DATA_W-1:0] o_win,
  output logic                o_sol,
  output logic                o_eol
);

  localparam int              H        = half_w(K);
  localparam int              PW       = $clog2(H + 1);
  localparam logic [PW-1:0]   H_CNT    = PW'(H);
  localparam logic [PW-1:0]   ONE      = PW'(1);
  localparam logic [DATA_W-1:0] ZERO_PIX = DATA_W'(PAD_ZERO);

  win_state_t          state;
  logic [PW-1:0]       pending;     // pixels accepted but not yet windowed
  logic                first_win;   // next window emitted is column 0
  logic                accept;
  logic                line_start;
  logic                shift_en;
  logic                load_en;
  logic [DATA_W-1:0]   shift_data;
  logic [K*DATA_W-1:0] load_win;
  logic [DATA_W-1:0]   left_pad;
  logic [DATA_W-1:0]   right_fill;
  logic [DATA_W-1:0]   flush_pad;
  int                  wr_pos;

  assign accept     = i_valid & o_ready;
  assign line_start = (state == FILL) && (pending == '0);

`ifdef WIN_BORDER_REPLICATE_EN
  logic [DATA_W-1:0] last_pix;   // most recent accepted pixel = p[N-1] in FLUSH

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       last_pix <= '0;
    else if (accept) last_pix <= i_data;
  end

  assign left_pad   = i_data;
  assign right_fill = i_data;
  assign flush_pad  = last_pix;
`else
  assign left_pad   = ZERO_PIX;
  assign right_fill = ZERO_PIX;
  assign flush_pad  = ZERO_PIX;
`endif

  // In FILL, pixel p[i] is written straight to tap H+1+i rather than shifted
  // in. Every tap to its right is set to the right-pad value, so a line that
  // ends while still filling (N <= H) already has its right border in place
  // and needs only one flush shift per pending pixel. Pixel p[0] also preloads
  // taps 0..H with the left pad, so nothing from the previous line survives.
  always_comb begin
    // NOTE: default first so every path assigns load_win and no latch forms.
    load_win = o_win;
    wr_pos   = H + 1 + int'(pending);
    for (int j = 0; j < K; j++) begin
      if (j == wr_pos)
        load_win[(K-1-j)*DATA_W +: DATA_W] = i_data;
      else if (j > wr_pos)
        load_win[(K-1-j)*DATA_W +: DATA_W] = right_fill;
      else if (line_start)
        load_win[(K-1-j)*DATA_W +: DATA_W] = left_pad;
    end
  end

  assign load_en    = accept && (state == FILL);
  assign shift_en   = (accept && (state == RUN)) || (state == FLUSH);
  assign shift_data = (state == FLUSH) ? flush_pad : i_data;

  win_shift_reg #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_taps (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .load_en    (load_en),
    .load_win   (load_win),
    .win        (o_win)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= FILL;
      pending   <= '0;
      first_win <= 1'b0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_sol     <= 1'b0;
      o_eol     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sol   <= 1'b0;
      o_eol   <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            pending <= pending + ONE;
            if (line_start) first_win <= 1'b1;
            if (i_eol) begin
              state   <= FLUSH;
              o_ready <= 1'b0;
            end else if (pending + ONE == H_CNT) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            o_valid   <= 1'b1;
            o_sol     <= first_win;
            first_win <= 1'b0;
            if (i_eol) begin
              state   <= FLUSH;
              o_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          o_valid   <= 1'b1;
          o_sol     <= first_win;
          first_win <= 1'b0;
          o_eol     <= (pending == ONE);
          pending   <= pending - ONE;
          if (pending == ONE) begin
            state   <= FILL;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          pending <= '0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_window_stream.sv
// -----------------------------------------------------------------------------
// tb_line_window_stream
// Bench for line_window_stream: a K=3 instance checked every cycle against a
// line-level window model, plus a K=5 instance checked with directed cases.
// Follows the build option WIN_BORDER_REPLICATE_EN for pad values.
// -----------------------------------------------------------------------------
module tb_line_window_stream;

`ifdef WIN_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  localparam int H3 = 1;

  typedef struct { logic [23:0] win; bit sol; bit eol; int due; } exp3_t;
  typedef struct { logic [23:0] win; bit sol; bit eol; } obs3_t;
  typedef struct { logic [39:0] win; bit sol; bit eol; } obs5_t;

  logic        i_clk   = 1'b0;
  logic        i_rst   = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data  = 8'd0;
  logic        i_eol   = 1'b0;
  logic        o_ready, o_valid, o_sol, o_eol;
  logic [23:0] o_win;

  logic        v5 = 1'b0;
  logic [7:0]  d5 = 8'd0;
  logic        eol5 = 1'b0;
  logic        r5, ov5, os5, oe5;
  logic [39:0] ow5;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int         e = 0;            // count of non-reset clock edges
  int         ready_edge = 0;   // o_ready is high after edges >= ready_edge
  int         last_acc_e = -1;  // edge at which the last pixel was accepted
  logic [7:0] cur_line[$];
  exp3_t      exp_q[$];
  int         rd_idx = 0;
  obs3_t      obs3[$];
  obs5_t      obs5[$];
  int         r3_low = 0;
  int         r5_low = 0;

  always #5 i_clk = ~i_clk;

  line_window_stream #(.DATA_W(8), .K(3)) u3 (
    .i_clk (i_clk), .i_rst (i_rst), .i_valid (i_valid), .i_data (i_data),
    .i_eol (i_eol), .o_ready (o_ready), .o_valid (o_valid), .o_win (o_win),
    .o_sol (o_sol), .o_eol (o_eol)
  );

  line_window_stream #(.DATA_W(8), .K(5)) u5 (
    .i_clk (i_clk), .i_rst (i_rst), .i_valid (v5), .i_data (d5),
    .i_eol (eol5), .o_ready (r5), .o_valid (ov5), .o_win (ow5),
    .o_sol (os5), .o_eol (oe5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window for column x of the current line: e(x-H)..e(x+H), pads outside.
  function automatic logic [23:0] model_win(input int x);
    logic [23:0] w;
    logic [7:0]  v;
    int          n;
    w = '0;
    n = cur_line.size();
    for (int t = x - H3; t <= x + H3; t++) begin
      if (t < 0)       v = REPL ? cur_line[0] : 8'd0;
      else if (t >= n) v = REPL ? cur_line[n-1] : 8'd0;
      else             v = cur_line[t];
      w = {w[15:0], v};
    end
    return w;
  endfunction

  task automatic push_win(input int x, input int due, input bit last);
    exp3_t it;
    it.win = model_win(x);
    it.sol = (x == 0);
    it.eol = last;
    it.due = due;
    exp_q.push_back(it);
  endtask

  // Line-level model: a window is due when p[x+H] is accepted, or, for the
  // columns that need right padding, one per cycle after the end of line.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_line.delete();
      exp_q.delete();
      ready_edge = e;
    end else begin
      e = e + 1;
      if (i_valid && (e - 1 >= ready_edge)) begin
        int n, first_flush;
        last_acc_e = e;
        cur_line.push_back(i_data);
        n = cur_line.size();
        if (!i_eol) begin
          if (n - 1 >= H3) push_win(n - 1 - H3, e, 1'b0);
        end else begin
          if (n > H3) push_win(n - 1 - H3, e, 1'b0);
          first_flush = (n > H3) ? n - H3 : 0;
          for (int x = first_flush; x < n; x++)
            push_win(x, e + (x - first_flush + 1), x == n - 1);
          ready_edge = e + ((n < H3) ? n : H3);
          cur_line.delete();
        end
      end
    end
  end

  // Compare process for the K=3 instance.
  always @(negedge i_clk) begin
    if (i_rst) begin
      rd_idx = 0;
    end else begin
      if (o_valid) obs3.push_back('{o_win, o_sol, o_eol});
      if (!o_ready) r3_low++;
      check("o_ready", o_ready, e >= ready_edge);
      if (rd_idx < exp_q.size() && exp_q[rd_idx].due == e) begin
        check("o_valid", o_valid, 1'b1);
        check("o_win", o_win, exp_q[rd_idx].win);
        check("o_sol", o_sol, exp_q[rd_idx].sol);
        check("o_eol", o_eol, exp_q[rd_idx].eol);
        rd_idx++;
      end else begin
        check("o_valid idle", o_valid, 1'b0);
      end
    end
  end

  // Collector for the K=5 instance.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (ov5) obs5.push_back('{ow5, os5, oe5});
      if (!r5) r5_low++;
    end
  end

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk); #1;
      i_data = 8'($urandom);
      i_eol  = 1'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit eol, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      i_data  = 8'($urandom);
      i_eol   = 1'($urandom);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b1;
    i_data  = d;
    i_eol   = eol;
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (last_acc_e != e && n < 20);
    check("accept within bound", last_acc_e == e, 1'b1);
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    i_eol   = 1'($urandom);
  endtask

  task automatic send5(input logic [7:0] d, input bit eol);
    v5 = 1'b1; d5 = d; eol5 = eol;
    @(posedge i_clk); #1;
    v5 = 1'b0; d5 = 8'($urandom); eol5 = 1'($urandom);
  endtask

  task automatic pin3(input string name, input int idx, input logic [23:0] win,
                      input bit sol, input bit eol);
    if (idx < obs3.size()) begin
      check({name, " win"}, obs3[idx].win, win);
      check({name, " sol"}, obs3[idx].sol, sol);
      check({name, " eol"}, obs3[idx].eol, eol);
    end else begin
      check({name, " present"}, obs3.size(), idx + 1);
    end
  endtask

  task automatic pin5(input string name, input int idx, input logic [39:0] win,
                      input bit sol, input bit eol);
    if (idx < obs5.size()) begin
      check({name, " win"}, obs5[idx].win, win);
      check({name, " sol"}, obs5[idx].sol, sol);
      check({name, " eol"}, obs5[idx].eol, eol);
    end else begin
      check({name, " present"}, obs5.size(), idx + 1);
    end
  endtask

  initial begin
    int base, low, len;

    repeat (3) @(posedge i_clk);
    #1;
    check("reset o_valid", o_valid, 1'b0);
    check("reset o_win", o_win, 24'h0);
    check("reset o_sol", o_sol, 1'b0);
    check("reset o_eol", o_eol, 1'b0);
    check("reset o_ready", o_ready, 1'b1);
    i_rst = 1'b0;
    idle(2);

    // Line 10,20,30,40
    base = obs3.size(); low = r3_low;
    send(8'd10, 1'b0, 0); send(8'd20, 1'b0, 0);
    send(8'd30, 1'b0, 0); send(8'd40, 1'b1, 0);
    idle(4);
    check("line4 count", obs3.size() - base, 4);
    pin3("line4 w0", base,     REPL ? 24'h0A0A14 : 24'h000A14, 1'b1, 1'b0);
    pin3("line4 w1", base + 1, 24'h0A141E, 1'b0, 1'b0);
    pin3("line4 w3", base + 3, REPL ? 24'h1E2828 : 24'h1E2800, 1'b0, 1'b1);
    check("line4 ready low cycles", r3_low - low, 1);

    // Single-pixel line
    base = obs3.size();
    send(8'd55, 1'b1, 0);
    idle(3);
    check("single count", obs3.size() - base, 1);
    pin3("single", base, REPL ? 24'h373737 : 24'h003700, 1'b1, 1'b1);

    // Two back-to-back lines with random gaps
    base = obs3.size();
    send(8'd1, 1'b0, $urandom_range(0, 3)); send(8'd2, 1'b0, $urandom_range(0, 3));
    send(8'd3, 1'b1, $urandom_range(0, 3));
    send(8'd200, 1'b0, 0); send(8'd201, 1'b0, $urandom_range(0, 3));
    send(8'd202, 1'b1, $urandom_range(0, 3));
    idle(4);
    check("two lines count", obs3.size() - base, 6);
    pin3("line B w0", base + 3, REPL ? 24'hC8C8C9 : 24'h00C8C9, 1'b1, 1'b0);

    // Reset in the middle of a line
    send(8'd90, 1'b0, 0); send(8'd91, 1'b0, 0);
    check("pre-reset o_valid", o_valid, 1'b1);
    i_rst = 1'b1;
    #1;
    check("mid rst o_valid", o_valid, 1'b0);
    check("mid rst o_win", o_win, 24'h0);
    check("mid rst o_sol", o_sol, 1'b0);
    check("mid rst o_ready", o_ready, 1'b1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    base = obs3.size();
    send(8'd7, 1'b0, 0); send(8'd8, 1'b1, 0);
    idle(3);
    check("after rst count", obs3.size() - base, 2);
    pin3("after rst w0", base,     REPL ? 24'h070708 : 24'h000708, 1'b1, 1'b0);
    pin3("after rst w1", base + 1, REPL ? 24'h070808 : 24'h070800, 1'b0, 1'b1);

    // Random lines
    for (int l = 0; l < 40; l++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++)
        send(8'($urandom), i == len - 1,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    idle(5);
    check("all windows seen", rd_idx, exp_q.size());

    // K=5: line 1..6
    base = obs5.size(); low = r5_low;
    for (int i = 1; i <= 6; i++) send5(8'(i), i == 6);
    idle(6);
    check("k5 count", obs5.size() - base, 6);
    pin5("k5 first", base,     REPL ? 40'h0101010203 : 40'h0000010203, 1'b1, 1'b0);
    pin5("k5 last",  base + 5, REPL ? 40'h0405060606 : 40'h0405060000, 1'b0, 1'b1);
    check("k5 ready low cycles", r5_low - low, 2);

    // K=5: single pixel (shorter than the half-width)
    base = obs5.size(); low = r5_low;
    send5(8'd55, 1'b1);
    idle(4);
    check("k5 single count", obs5.size() - base, 1);
    pin5("k5 single", base, REPL ? 40'h3737373737 : 40'h0000370000, 1'b1, 1'b1);
    check("k5 single ready low", r5_low - low, 1);

    // K=5: two-pixel line (length equal to the half-width)
    base = obs5.size(); low = r5_low;
    send5(8'd9, 1'b0); send5(8'd11, 1'b1);
    idle(4);
    check("k5 pair count", obs5.size() - base, 2);
    pin5("k5 pair w0", base,     REPL ? 40'h0909090B0B : 40'h0000090B00, 1'b1, 1'b0);
    pin5("k5 pair w1", base + 1, REPL ? 40'h09090B0B0B : 40'h00090B0000, 1'b0, 1'b1);
    check("k5 pair ready low", r5_low - low, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
